// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM state encoding and index-width helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter, bundled with arbiter (slave)
// and environment (master) views.
interface mem_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 8,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we_req;
  logic [NREQ*AW-1:0] addr_req;
  logic [NREQ*DW-1:0] wdata_req;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [DW-1:0]      rdata;
  logic [AW-1:0]      mem_addr;
  logic               mem_re;
  logic               mem_we;
  logic [DW-1:0]      mem_wdata;
  logic               mem_drive;
  logic [DW-1:0]      mem_rdata;

  modport slave (
    input  req, we_req, addr_req, wdata_req, mem_rdata,
    output gnt, done, rdata, mem_addr, mem_re, mem_we, mem_wdata, mem_drive
  );

  modport master (
    output req, we_req, addr_req, wdata_req, mem_rdata,
    input  gnt, done, rdata, mem_addr, mem_re, mem_we, mem_wdata, mem_drive
  );
endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin search: first set request after the last winner, wrapping.
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic            any_o,
  output logic [IW-1:0]   winner_o
);

  logic [IW-1:0] cand;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    any_o    = 1'b0;
    winner_o = '0;
    cand     = '0;
    // Scan from the farthest candidate back to the nearest so the nearest wins.
    for (int k = NREQ; k >= 1; k--) begin
      cand = IW'((int'(last_i) + k) % NREQ);
      if (req_i[cand]) begin
        any_o    = 1'b1;
        winner_o = cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory: IDLE -> ACCESS -> DONE,
// one memory cycle per transaction, all outputs driven straight from registers.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = 8,
  parameter int DW   = 8
) (
  input logic          clock,
  input logic          reset_L,
  mem_arbiter_if.slave bus
);

  localparam int IW = idx_w(NREQ);

  state_e          state_q;
  logic [IW-1:0]   win_q;
  logic [IW-1:0]   last_q;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   rdata_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] done_q;
  logic            mem_re_q;
  logic            mem_we_q;

  logic            pick_any;
  logic [IW-1:0]   pick_idx;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req_i    (bus.req),
    .last_i   (last_q),
    .any_o    (pick_any),
    .winner_o (pick_idx)
  );

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= IDLE;
      win_q    <= '0;
      last_q   <= IW'(NREQ - 1);
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      mem_re_q <= 1'b0;
      mem_we_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            win_q    <= pick_idx;
            we_q     <= bus.we_req[pick_idx];
            addr_q   <= bus.addr_req[int'(pick_idx) * AW +: AW];
            wdata_q  <= bus.wdata_req[int'(pick_idx) * DW +: DW];
            gnt_q    <= NREQ'(1) << pick_idx;
            mem_re_q <= ~bus.we_req[pick_idx];
            mem_we_q <= bus.we_req[pick_idx];
            state_q  <= ACCESS;
          end
        end
        ACCESS: begin
          // The memory read data is only valid during this single cycle.
          if (!we_q) rdata_q <= bus.mem_rdata;
          mem_re_q <= 1'b0;
          mem_we_q <= 1'b0;
          done_q   <= gnt_q;
          state_q  <= DONE;
        end
        DONE: begin
          done_q  <= '0;
          gnt_q   <= '0;
          last_q  <= win_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_drive = mem_we_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic,
// compared every cycle against a transaction-level model and a shadow memory.
module tb_mem_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 8;
  localparam int DW   = 8;

  logic clock   = 1'b0;
  logic reset_L = 1'b0;
  always #5 clock = ~clock;

  mem_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clock   (clock),
    .reset_L (reset_L),
    .bus     (bus)
  );

  // Behavioural single-port memory on the far side of the arbiter.
  logic [DW-1:0] mem [256];
  bit            mem_fill = 1'b1;
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clock) begin
    if (mem_fill) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 3);
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  // Reference model state.
  logic [DW-1:0]   ref_mem [256];
  int              cur  = -1;
  int              age  = 0;
  int              last = NREQ - 1;
  logic            m_we = 1'b0;
  logic [AW-1:0]   m_addr = '0;
  logic [DW-1:0]   m_wdata = '0;
  logic [DW-1:0]   exp_rdata = '0;
  logic [NREQ-1:0] keep = '0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input int idx);
    logic [NREQ-1:0] v;
    v = '0;
    if (idx >= 0) v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin rule: first active requester after the previous winner, wrapping.
  function automatic int pick(input logic [NREQ-1:0] r, input int prev);
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (prev + k) % NREQ;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic check_outputs();
    logic [NREQ-1:0] oh;
    oh = onehot(cur);
    check("gnt",       32'(bus.gnt),       32'(oh));
    check("done",      32'(bus.done),      32'((cur >= 0 && age == 2) ? oh : '0));
    check("mem_re",    32'(bus.mem_re),    32'(cur >= 0 && age == 1 && !m_we));
    check("mem_we",    32'(bus.mem_we),    32'(cur >= 0 && age == 1 && m_we));
    check("mem_drive", 32'(bus.mem_drive), 32'(cur >= 0 && age == 1 && m_we));
    check("mem_addr",  32'(bus.mem_addr),  32'(m_addr));
    check("mem_wdata", 32'(bus.mem_wdata), 32'(m_wdata));
    check("rdata",     32'(bus.rdata),     32'(exp_rdata));
  endtask

  // Advance one clock: apply the upcoming edge to the model, then check at the negedge.
  task automatic cycle();
    if (cur < 0) begin
      if (bus.req != '0) begin
        cur     = pick(bus.req, last);
        age     = 1;
        m_we    = bus.we_req[cur];
        m_addr  = bus.addr_req[cur*AW +: AW];
        m_wdata = bus.wdata_req[cur*DW +: DW];
      end
    end else if (age == 1) begin
      age = 2;
      if (m_we) ref_mem[m_addr] = m_wdata;
      else      exp_rdata = ref_mem[m_addr];
    end else begin
      last = cur;
      cur  = -1;
      age  = 0;
    end
    @(negedge clock);
    check_outputs();
  endtask

  task automatic set_cmd(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.we_req[i]             = w;
    bus.addr_req[i*AW +: AW]  = a;
    bus.wdata_req[i*DW +: DW] = d;
    bus.req[i]                = 1'b1;
  endtask

  // Called at a negedge; asserts reset mid-cycle and checks the asynchronous clear.
  task automatic do_reset();
    #2 reset_L = 1'b0;
    #1;
    cur = -1; age = 0; last = NREQ - 1;
    m_we = 1'b0; m_addr = '0; m_wdata = '0; exp_rdata = '0;
    check_outputs();
    @(negedge clock);
    check_outputs();
    reset_L = 1'b1;
  endtask

  // One full transaction from an idle arbiter, expecting requester idx to win.
  task automatic serve(input int idx);
    cycle();
    check("serve_gnt", 32'(bus.gnt), 32'(onehot(idx)));
    cycle();
    check("serve_done", 32'(bus.done), 32'(onehot(idx)));
    if (!keep[idx]) bus.req[idx] = 1'b0;
    cycle();
  endtask

  initial begin
    bus.req       = '0;
    bus.we_req    = '0;
    bus.addr_req  = '0;
    bus.wdata_req = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);

    // Reset state.
    @(negedge clock);
    @(negedge clock);
    mem_fill = 1'b0;
    check_outputs();
    reset_L = 1'b1;

    // Requester 1 writes A5 to 10, then reads it back.
    set_cmd(1, 1'b1, 8'h10, 8'hA5);
    cycle();
    check("t1_we",    32'(bus.mem_we),    32'd1);
    check("t1_addr",  32'(bus.mem_addr),  32'h10);
    check("t1_wdata", 32'(bus.mem_wdata), 32'hA5);
    cycle();
    check("t1_wr_done", 32'(bus.done), 32'b0010);
    bus.req[1] = 1'b0;
    cycle();
    check("t1_we_off", 32'(bus.mem_we), 32'd0);
    set_cmd(1, 1'b0, 8'h10, 8'h00);
    serve(1);
    check("t1_rdata", 32'(bus.rdata), 32'hA5);

    // All four read together straight out of reset.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_cmd(i, 1'b0, 8'(8'h20 + i), 8'h00);
    for (int i = 0; i < NREQ; i++) serve(i);

    // Requesters 0 and 2 held continuously alternate.
    keep = 4'b0101;
    set_cmd(0, 1'b1, 8'h30, 8'h3C);
    set_cmd(2, 1'b0, 8'h30, 8'h00);
    serve(0);
    serve(2);
    serve(0);
    serve(2);
    keep = '0;
    bus.req = '0;
    cycle();

    // Reset during a write's ACCESS; lowest active index wins afterwards.
    set_cmd(2, 1'b1, 8'h40, 8'h77);
    cycle();
    check("t4_in_access", 32'(bus.mem_we), 32'd1);
    set_cmd(1, 1'b0, 8'h41, 8'h00);
    set_cmd(3, 1'b0, 8'h42, 8'h00);
    do_reset();
    serve(1);
    serve(2);
    serve(3);

    // Requester 3 pulses during requester 0's ACCESS and is never served.
    set_cmd(0, 1'b0, 8'h10, 8'h00);
    cycle();
    set_cmd(3, 1'b1, 8'h50, 8'h99);
    cycle();
    bus.req[0] = 1'b0;
    bus.req[3] = 1'b0;
    cycle();
    cycle();
    check("t5_no_gnt", 32'(bus.gnt), 32'd0);

    // Inputs changed during ACCESS do not disturb the latched command.
    set_cmd(1, 1'b0, 8'h10, 8'h00);
    cycle();
    bus.addr_req[1*AW +: AW]  = 8'hEE;
    bus.we_req[1]             = 1'b1;
    bus.wdata_req[1*DW +: DW] = 8'h55;
    cycle();
    check("t6_addr",  32'(bus.mem_addr), 32'h10);
    check("t6_rdata", 32'(bus.rdata),    32'hA5);
    bus.req[1] = 1'b0;
    cycle();

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      cycle();
      if (cur >= 0 && age == 2) begin
        if ($urandom_range(0, 99) < 40)
          set_cmd(cur, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
        else
          bus.req[cur] = 1'b0;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (i != cur) begin
          if (!bus.req[i]) begin
            if ($urandom_range(0, 99) < 30)
              set_cmd(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
          end else if ($urandom_range(0, 99) < 5) begin
            bus.req[i] = 1'b0;
          end
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter and access sequencer that shares one single-port `Memory` instance (AW address bits, DW data bits) between NREQ requesters. It latches the winning requester's command, drives the memory's address, read-enable, write-enable and data-bus-drive signals for exactly one access cycle, and returns read data with a one-cycle `done` pulse. It sits between the requesting datapath blocks and the memory/`BusDriver` pair at the top level.

## Interface
- NREQ, 4, number of requesters (2..8)
- AW, 8, memory address width
- DW, 8, memory data width
- clock  in  1  system clock, all state changes on rising edge
- reset_L  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester access request; held until matching `done`
- we_req  in  NREQ  per-requester op select: 1 write, 0 read
- addr_req  in  NREQ*AW  flattened addresses; requester i at [i*AW +: AW]
- wdata_req  in  NREQ*DW  flattened write data; requester i at [i*DW +: DW]
- gnt  out  NREQ  one-hot grant, high from ACCESS through DONE
- done  out  NREQ  one-hot, one-cycle completion pulse
- rdata  out  DW  read data, valid while `done` is high after a read
- mem_addr  out  AW  memory address
- mem_re  out  1  memory read enable
- mem_we  out  1  memory write enable
- mem_wdata  out  DW  write data toward the bus driver
- mem_drive  out  1  bus driver enable; equals mem_we
- mem_rdata  in  DW  data read back from the memory bus

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: if any req bit is set, choose the winner by round-robin. Search starts at (last+1) mod NREQ and wraps. At the edge, latch the winner index, we_req[w], addr_req slice and wdata_req slice, then go to ACCESS. With no requests, stay in IDLE.
- ACCESS (one cycle):
  - mem_addr = latched address.
  - Read: mem_re=1, and rdata captures mem_rdata at the closing edge.
  - Write: mem_we=1, mem_drive=1, mem_wdata = latched data; the memory commits at the closing edge.
  - Go to DONE.
- DONE (one cycle): done[w]=1 and gnt[w] stays 1. On a read, rdata holds the captured value. last←w. Go to IDLE.
- mem_re and mem_we are never high together. Both are 0 outside ACCESS.
- mem_addr and mem_wdata hold their latched values outside ACCESS.
- rdata holds its value until the next read completes. A write leaves rdata unchanged.
- Requester rules:
  - Hold req, we_req, addr and wdata stable from assertion until done is seen.
  - Deassert req at the edge that ends DONE, or keep it high to make a new request.
  - A req still high in IDLE is a new request.
- Boundary cases:
  - req dropped before it is granted: ignored, no access.
  - req or inputs changed during ACCESS or DONE: the latched command completes unaffected.
  - All requesters active: each is served once per NREQ transactions, in rotating order.
  - A single requester asserting continuously: served every 3 cycles.
- Reset (asynchronous, including mid-ACCESS):
  - State goes to IDLE and last=NREQ-1, so requester 0 has priority first.
  - gnt, done, rdata, mem_addr, mem_re, mem_we, mem_wdata and mem_drive all go to 0.
  - An interrupted write may or may not have reached the memory.

## Timing
- Request sampled in IDLE at edge t: ACCESS during cycle t..t+1, DONE during t+1..t+2, IDLE from t+2.
- Latency from request to done: 2 cycles. Throughput: one access per 3 cycles.
- Memory control outputs are decoded from the state register and latched command registers only. There is no combinational path from req or mem_rdata to any output.
- mem_rdata is sampled only at the edge that ends ACCESS.

## Structure
- Package `mem_arb_pkg`: state enum (IDLE, ACCESS, DONE) as a 2-bit logic typedef.
- Sub-module `rr_picker`:
  - Parameter NREQ.
  - Inputs: req, last pointer.
  - Outputs: `any` flag and winner index ($clog2(NREQ) bits).
  - Purely combinational rotate-search.
- Top: FSM, command latch registers, rdata register, last pointer, output decode.

## Test plan
- Reset, then requester 1 writes 8'hA5 to addr 8'h10; requester 1 later reads 8'h10 → mem_we high exactly one cycle with mem_addr=10/mem_wdata=A5; done[1] pulses 2 cycles after each request; rdata=A5 with read done.
- All four requesters read simultaneously from reset, held until done → grants in order 0,1,2,3, spaced 3 cycles; each done one-hot and matching its gnt.
- Requesters 0 and 2 held continuously → grants alternate 0,2,0,2; neither starved.
- reset_L pulled low mid-ACCESS of a write → all outputs 0 immediately; after release, the first grant goes to the lowest-index active requester.
- Requester 3 pulses req for one cycle while requester 0's access is in ACCESS → no grant or done for 3.
- Requester changes addr_req during ACCESS → mem_addr keeps the latched value.
